// File: rtl/edgedetect_pkg.sv
// Shared types and arithmetic for the edge-detect pipeline: FSM states,
// Sobel kernels and the magnitude saturation helper.
package edgedetect_pkg;

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_RUN, S_DRAIN, S_DONE} state_t;

  // Row index 0 is the oldest (top) line, column index 0 the oldest (left) pixel.
  localparam int SOBEL_KX [3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
  localparam int SOBEL_KY [3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};

  function automatic int sat_mag(int gx, int gy, int max_v);
    int s;
    s = ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
    return (s > max_v) ? max_v : s;
  endfunction

endpackage

// File: rtl/sobel_linebuf.sv
// Circular single-row delay line: dout is the sample written len shifts ago.
// Storage is not reset; only the pointer is.
module sobel_linebuf #(
  parameter int PIX_W     = 8,
  parameter int MAX_WIDTH = 1024,
  parameter int DIM_W     = 11
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             shift,
  input  logic [DIM_W-1:0] len,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] dout
);

  localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

  logic [PIX_W-1:0] mem [MAX_WIDTH];
  logic [AW-1:0]    ptr;

  assign dout = mem[ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)     ptr <= '0;
    else if (clr)   ptr <= '0;
    else if (shift) ptr <= (DIM_W'(ptr) == len - DIM_W'(1)) ? '0 : ptr + AW'(1);
  end

  always_ff @(posedge clock) begin
    if (shift) mem[ptr] <= din;
  end

endmodule

// File: rtl/sobel_stream.sv
// Runtime-sized streaming Sobel engine, FIFO in / FIFO out, one frame per start.
// Optional SOBEL_THRESHOLD_EN adds cfg_threshold and binarises the output.
module sobel_stream
  import edgedetect_pkg::*;
#(
  parameter int PIX_W      = 8,
  parameter int MAX_WIDTH  = 1024,
  parameter int MAX_HEIGHT = 1024,
  parameter int DIM_W      = 11
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [DIM_W-1:0] cfg_width,
  input  logic [DIM_W-1:0] cfg_height,
`ifdef SOBEL_THRESHOLD_EN
  input  logic [PIX_W-1:0] cfg_threshold,
`endif
  output logic             in_rd_en,
  input  logic             in_empty,
  input  logic [PIX_W-1:0] in_dout,
  output logic             out_wr_en,
  input  logic             out_full,
  output logic [PIX_W-1:0] out_din,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  localparam int CNT_W = 2 * DIM_W;

  typedef struct packed {
    logic [DIM_W-1:0] w;
    logic [DIM_W-1:0] h;
  } frame_cfg_t;

  state_t                     state, state_nx;
  frame_cfg_t                 cfg_q;
  logic [CNT_W-1:0]           npix_q, in_cnt;
  logic [DIM_W-1:0]           out_row, out_col;
  logic [2:0][2:0][PIX_W-1:0] win;
  logic [1:0][PIX_W-1:0]      lb_din, lb_dout;
  logic                       cfg_ok, idle_start, shift, last_out, border;
  logic [PIX_W-1:0]           new_px, mag;
  logic signed [PIX_W+2:0]    gx, gy;

  assign cfg_ok = (cfg_width  >= DIM_W'(3)) && (cfg_width  <= DIM_W'(MAX_WIDTH)) &&
                  (cfg_height >= DIM_W'(3)) && (cfg_height <= DIM_W'(MAX_HEIGHT));
  assign idle_start = (state == S_IDLE) && start;

  assign in_rd_en  = !in_empty && ((state == S_FILL) || ((state == S_RUN) && !out_full));
  assign out_wr_en = !out_full && (((state == S_RUN) && !in_empty) || (state == S_DRAIN));
  assign shift     = in_rd_en || out_wr_en;
  assign new_px    = (state == S_DRAIN) ? '0 : in_dout;
  assign busy      = (state == S_FILL) || (state == S_RUN) || (state == S_DRAIN);
  assign done      = (state == S_DONE);
  assign last_out  = out_wr_en && (out_row == cfg_q.h - DIM_W'(1)) &&
                     (out_col == cfg_q.w - DIM_W'(1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (idle_start && cfg_ok) state_nx = S_FILL;
      S_FILL:  if (in_rd_en && (in_cnt == CNT_W'(cfg_q.w) + CNT_W'(1))) state_nx = S_RUN;
      S_RUN:   if (in_rd_en && (in_cnt == npix_q - CNT_W'(1))) state_nx = S_DRAIN;
      S_DRAIN: if (last_out) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Output coordinates return to (0,0) after the last pixel so idle out_din reads as border.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cfg_q   <= '0;
      npix_q  <= '0;
      in_cnt  <= '0;
      out_row <= '0;
      out_col <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= idle_start && !cfg_ok;
      if (idle_start) begin
        cfg_q   <= '{w: cfg_width, h: cfg_height};
        npix_q  <= CNT_W'(cfg_width) * CNT_W'(cfg_height);
        in_cnt  <= '0;
        out_row <= '0;
        out_col <= '0;
      end else begin
        if (in_rd_en) in_cnt <= in_cnt + CNT_W'(1);
        if (last_out) begin
          out_row <= '0;
          out_col <= '0;
        end else if (out_wr_en) begin
          if (out_col == cfg_q.w - DIM_W'(1)) begin
            out_col <= '0;
            out_row <= out_row + DIM_W'(1);
          end else begin
            out_col <= out_col + DIM_W'(1);
          end
        end
      end
    end
  end

  // Window column 2 takes the newest pixel plus the same column one and two lines back.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      win <= '0;
    end else if (shift) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[2][2] <= new_px;
      win[1][2] <= lb_dout[0];
      win[0][2] <= lb_dout[1];
    end
  end

  assign lb_din[0] = new_px;
  assign lb_din[1] = lb_dout[0];

  for (genvar g = 0; g < 2; g++) begin : g_lb
    sobel_linebuf #(.PIX_W(PIX_W), .MAX_WIDTH(MAX_WIDTH), .DIM_W(DIM_W)) u_lb (
      .clock (clock),
      .reset (reset),
      .clr   (idle_start),
      .shift (shift),
      .len   (cfg_q.w),
      .din   (lb_din[g]),
      .dout  (lb_dout[g])
    );
  end

  always_comb begin : p_grad
    int ax;
    int ay;
    ax = 0;
    ay = 0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        ax += SOBEL_KX[r][c] * int'(win[r][c]);
        ay += SOBEL_KY[r][c] * int'(win[r][c]);
      end
    end
    gx = (PIX_W+3)'(ax);
    gy = (PIX_W+3)'(ay);
  end

  assign mag    = PIX_W'(sat_mag(int'(gx), int'(gy), 2**PIX_W - 1));
  assign border = (out_row == '0) || (out_row == cfg_q.h - DIM_W'(1)) ||
                  (out_col == '0) || (out_col == cfg_q.w - DIM_W'(1));

`ifdef SOBEL_THRESHOLD_EN
  logic [PIX_W-1:0] thr_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)          thr_q <= '0;
    else if (idle_start) thr_q <= cfg_threshold;
  end

  assign out_din = (border || (mag < thr_q)) ? '0 : '1;
`else
  assign out_din = border ? '0 : mag;
`endif

endmodule

// File: tb/tb_sobel_stream.sv
// Randomised scoreboard bench for sobel_stream: FIFO models on both sides,
// a direct 2-D Sobel reference model, and a negedge output monitor.
module tb_sobel_stream;

  localparam int PIX_W      = 8;
  localparam int MAX_WIDTH  = 1024;
  localparam int MAX_HEIGHT = 1024;
  localparam int DIM_W      = 11;
`ifdef SOBEL_THRESHOLD_EN
  localparam bit USE_THR = 1'b1;
`else
  localparam bit USE_THR = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset, start;
  logic [DIM_W-1:0] cfg_width, cfg_height;
`ifdef SOBEL_THRESHOLD_EN
  logic [PIX_W-1:0] cfg_threshold;
`endif
  logic             in_rd_en, in_empty;
  logic [PIX_W-1:0] in_dout;
  logic             out_wr_en, out_full;
  logic [PIX_W-1:0] out_din;
  logic             busy, done, cfg_err;

  int tests = 0, errors = 0;
  int done_cnt = 0, rd_cnt = 0, out_cnt = 0;
  int stall_mode = 0, cyc = 0, thr_cur = 0;
  int src_q[$];
  int exp_q[$];
  bit acc_in = 1'b0;

  sobel_stream #(.PIX_W(PIX_W), .MAX_WIDTH(MAX_WIDTH), .MAX_HEIGHT(MAX_HEIGHT), .DIM_W(DIM_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .cfg_width    (cfg_width),
    .cfg_height   (cfg_height),
`ifdef SOBEL_THRESHOLD_EN
    .cfg_threshold(cfg_threshold),
`endif
    .in_rd_en     (in_rd_en),
    .in_empty     (in_empty),
    .in_dout      (in_dout),
    .out_wr_en    (out_wr_en),
    .out_full     (out_full),
    .out_din      (out_din),
    .busy         (busy),
    .done         (done),
    .cfg_err      (cfg_err)
  );

  always #5 clock = ~clock;

  task automatic chk(string name, int got, int exp);
    tests++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Upstream/downstream FIFO models: pop what the DUT took, then re-roll stalls.
  initial begin
    in_empty = 1'b1;
    in_dout  = '0;
    out_full = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (acc_in && src_q.size() > 0) void'(src_q.pop_front());
      cyc++;
      case (stall_mode)
        1:       out_full = (cyc % 3 == 0);
        2:       out_full = ($urandom_range(0, 3) == 0);
        default: out_full = 1'b0;
      endcase
      in_empty = (src_q.size() == 0) || (stall_mode != 0 && $urandom_range(0, 2) == 0);
      in_dout  = (src_q.size() > 0) ? PIX_W'(src_q[0]) : '0;
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      acc_in = in_rd_en;
      if (reset) begin
        if (in_rd_en && in_empty) chk("rd_while_empty", 1, 0);
        if (out_wr_en && out_full) chk("wr_while_full", 1, 0);
        if (in_rd_en) rd_cnt++;
        if (done) done_cnt++;
        if (out_wr_en) begin
          out_cnt++;
          if (exp_q.size() == 0) chk("unexpected_output", int'(out_din), -1);
          else chk("out_din", int'(out_din), exp_q.pop_front());
        end
      end
    end
  end

  // Reference: full-frame Sobel straight from the 2-D neighbourhood definition.
  task automatic load_frame(int w, int h, int kind, int mode, int thr);
    int px[];
    px = new[w * h];
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        case (kind)
          1:       px[r*w+c] = 128;
          2:       px[r*w+c] = (c < w / 2) ? 0 : 255;
          3:       px[r*w+c] = (c * 10) % 256;
          default: px[r*w+c] = int'($urandom_range(0, 255));
        endcase
    foreach (px[i]) src_q.push_back(px[i]);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        int gx, gy, m;
        gx = 0; gy = 0; m = 0;
        if (r > 0 && r < h - 1 && c > 0 && c < w - 1) begin
          for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++) begin
              gx += dc * ((dr == 0) ? 2 : 1) * px[(r+dr)*w + c + dc];
              gy += dr * ((dc == 0) ? 2 : 1) * px[(r+dr)*w + c + dc];
            end
          m = ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
          if (m > 255) m = 255;
          if (USE_THR) m = (m >= thr) ? 255 : 0;
        end
        exp_q.push_back(m);
      end
    end
    stall_mode = mode;
    thr_cur    = thr;
  endtask

  task automatic start_frame(int w, int h);
    @(posedge clock);
    #1;
    start      = 1'b1;
    cfg_width  = DIM_W'(w);
    cfg_height = DIM_W'(h);
`ifdef SOBEL_THRESHOLD_EN
    cfg_threshold = PIX_W'(thr_cur);
`endif
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(string name, int d0, int budget);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clock);
      n++;
    end
    #1;
    if (done_cnt == d0) begin
      chk({name, "_timeout"}, 0, 1);
      reset = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b1;
    end
    repeat (3) @(posedge clock);
    #1;
    chk({name, "_done_pulses"}, done_cnt - d0, 1);
    chk({name, "_outputs_left"}, exp_q.size(), 0);
    chk({name, "_inputs_left"}, src_q.size(), 0);
    chk({name, "_busy_after"}, int'(busy), 0);
    exp_q.delete();
    src_q.delete();
  endtask

  task automatic run_frame(string name, int w, int h, int kind, int mode, int thr);
    int d0;
    load_frame(w, h, kind, mode, thr);
    d0 = done_cnt;
    start_frame(w, h);
    wait_done(name, d0, 20 * w * h + 200);
  endtask

  task automatic bad_start(string name, int w, int h);
    int r0;
    stall_mode = 0;
    for (int i = 0; i < 6; i++) src_q.push_back(i);
    @(posedge clock);
    #1;
    r0 = rd_cnt;
    start_frame(w, h);
    chk({name, "_cfg_err"}, int'(cfg_err), 1);
    chk({name, "_busy"}, int'(busy), 0);
    @(posedge clock);
    #1;
    chk({name, "_cfg_err_clear"}, int'(cfg_err), 0);
    repeat (4) @(posedge clock);
    #1;
    chk({name, "_no_reads"}, rd_cnt - r0, 0);
    chk({name, "_idle"}, int'(busy), 0);
    src_q.delete();
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0, o0, n;
    reset = 1'b0; start = 1'b0; cfg_width = '0; cfg_height = '0;
`ifdef SOBEL_THRESHOLD_EN
    cfg_threshold = '0;
`endif
    repeat (3) @(posedge clock);
    #1;
    chk("reset_ctrl", int'({in_rd_en, out_wr_en, busy, done, cfg_err}), 0);
    chk("reset_out_din", int'(out_din), 0);
    reset = 1'b1;

    run_frame("const128", 4, 4, 1, 0, 0);
    run_frame("step", 4, 4, 2, 0, 0);
    run_frame("ramp", 4, 4, 3, 0, 0);
    run_frame("ramp_stall", 4, 4, 3, 1, 0);
    bad_start("w2", 2, 4);
    bad_start("wmax1", MAX_WIDTH + 1, 4);
    bad_start("h2", 5, 2);

    // Abort a frame mid-stream, then confirm a fresh frame is clean.
    load_frame(8, 6, 0, 0, 0);
    d0 = done_cnt;
    o0 = out_cnt;
    start_frame(8, 6);
    n = 0;
    while (out_cnt < o0 + 5 && n < 500) begin
      @(posedge clock);
      n++;
    end
    #1;
    chk("abort_reached_run", int'(out_cnt >= o0 + 5), 1);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("abort_reset_ctrl", int'({in_rd_en, out_wr_en, busy, done}), 0);
    src_q.delete();
    exp_q.delete();
    reset = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    chk("abort_no_done", done_cnt - d0, 0);
    run_frame("after_abort_5x3", 5, 3, 0, 0, 0);

    run_frame("min_3x3", 3, 3, 0, 2, 0);
    for (int i = 0; i < 6; i++)
      run_frame("random", int'($urandom_range(3, 12)), int'($urandom_range(3, 9)), 0, 2, 0);
    run_frame("max_width", MAX_WIDTH, 3, 0, 2, 0);

    if (USE_THR) begin
      run_frame("thr80", 4, 4, 3, 0, 80);
      run_frame("thr81", 4, 4, 3, 0, 81);
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
